// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encodings, the per-cycle control word and counter sizing.
package pipe_hazard_pkg;

    localparam int CNT_W    = 4;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LSTALL  = 2'b01,
        REDIR   = 2'b10,
        ILLEGAL = 2'b11
    } hz_state_e;

    // One cycle's worth of pipeline-register control.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
    localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
    localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard sources in, pipeline stall/flush controls out.
// The statistics counters exist only when PIPE_HAZARD_STATS_EN is defined.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] ID_rs;
    logic [REG_W-1:0] ID_rt;
    logic             ID_uses_rt;
    logic             EX_MemRead;
    logic [REG_W-1:0] EX_rd;
    logic             ID_branch_taken;
    logic             ID_jump;

    logic             PC_write;
    logic             IFID_write;
    logic             IFID_flush;
    logic             IDEX_flush;
    logic [1:0]       hz_state;
    logic             stall_active;
`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      flush_cnt;
`endif

    // Pipeline side: supplies hazard sources, consumes controls.
    modport master (
        output ID_rs, ID_rt, ID_uses_rt, EX_MemRead, EX_rd, ID_branch_taken, ID_jump,
        input  PC_write, IFID_write, IFID_flush, IDEX_flush, hz_state, stall_active
`ifdef PIPE_HAZARD_STATS_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rt, EX_MemRead, EX_rd, ID_branch_taken, ID_jump,
        output PC_write, IFID_write, IFID_flush, IDEX_flush, hz_state, stall_active
`ifdef PIPE_HAZARD_STATS_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use and redirect detection; kept separate so the
// forwarding unit can reuse the same equations.
module hazard_detect
    import pipe_hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rt,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_rd,
    input  logic             ID_branch_taken,
    input  logic             ID_jump,
    output logic             load_use,
    output logic             redirect
);

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign load_use = EX_MemRead
                    & (EX_rd != REG_W'(REG_ZERO))
                    & ((EX_rd == ID_rs) | (ID_uses_rt & (EX_rd == ID_rt)));

    assign redirect = ID_branch_taken | ID_jump;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: posedge FSM plus down-counter
// stretching load-use stalls and redirect flushes. Optional PIPE_HAZARD_STATS_EN adds counters.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES  = 1,
    parameter int REDIR_FLUSH_CYCLES = 1,
    parameter int REG_W              = 5
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    hz_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    ctrl_t            ctrl;
    logic             load_use;
    logic             redirect;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .ID_rs           (hz.ID_rs),
        .ID_rt           (hz.ID_rt),
        .ID_uses_rt      (hz.ID_uses_rt),
        .EX_MemRead      (hz.EX_MemRead),
        .EX_rd           (hz.EX_rd),
        .ID_branch_taken (hz.ID_branch_taken),
        .ID_jump         (hz.ID_jump),
        .load_use        (load_use),
        .redirect        (redirect)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ctrl      = CTRL_RUN;

        unique case (state)
            RUN: begin
                if (load_use) begin
                    ctrl = CTRL_STALL;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_nxt = LSTALL;
                        cnt_nxt   = CNT_W'(LOAD_STALL_CYCLES - 1);
                    end
                end else if (redirect) begin
                    ctrl = CTRL_FLUSH;
                    if (REDIR_FLUSH_CYCLES > 1) begin
                        state_nxt = REDIR;
                        cnt_nxt   = CNT_W'(REDIR_FLUSH_CYCLES - 1);
                    end
                end
            end
            LSTALL, REDIR: begin
                ctrl = (state == LSTALL) ? CTRL_STALL : CTRL_FLUSH;
                // Leaving at cnt<=1 keeps the counter from ever wrapping below zero.
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                ctrl      = CTRL_STALL;
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase

        // Reset overrides everything so a mid-stall reset still bubbles the pipe.
        if (rst) begin
            ctrl = CTRL_RESET;
        end
    end

    assign hz.PC_write     = ctrl.pc_write;
    assign hz.IFID_write   = ctrl.ifid_write;
    assign hz.IFID_flush   = ctrl.ifid_flush;
    assign hz.IDEX_flush   = ctrl.idex_flush;
    assign hz.hz_state     = state;
    assign hz.stall_active = ~ctrl.pc_write;

`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!ctrl.pc_write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ctrl.ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances with different stall/flush
// lengths; inputs change just after posedge, outputs are checked at negedge.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(5)) if_a ();
    pipe_hazard_ctrl_if #(.REG_W(5)) if_b ();
    pipe_hazard_ctrl_if #(.REG_W(5)) if_c ();

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .REDIR_FLUSH_CYCLES(1), .REG_W(5))
        dut_a (.clk(clk), .rst(rst), .hz(if_a.slave));
    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .REDIR_FLUSH_CYCLES(2), .REG_W(5))
        dut_b (.clk(clk), .rst(rst), .hz(if_b.slave));
    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(4), .REDIR_FLUSH_CYCLES(1), .REG_W(5))
        dut_c (.clk(clk), .rst(rst), .hz(if_c.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Idle inputs: distinct source/destination registers, nothing in flight.
    task automatic idle_all();
        if_a.ID_rs = 5'd1; if_a.ID_rt = 5'd2; if_a.ID_uses_rt = 1'b0; if_a.EX_MemRead = 1'b0;
        if_a.EX_rd = 5'd0; if_a.ID_branch_taken = 1'b0; if_a.ID_jump = 1'b0;
        if_b.ID_rs = 5'd1; if_b.ID_rt = 5'd2; if_b.ID_uses_rt = 1'b0; if_b.EX_MemRead = 1'b0;
        if_b.EX_rd = 5'd0; if_b.ID_branch_taken = 1'b0; if_b.ID_jump = 1'b0;
        if_c.ID_rs = 5'd1; if_c.ID_rt = 5'd2; if_c.ID_uses_rt = 1'b0; if_c.EX_MemRead = 1'b0;
        if_c.EX_rd = 5'd0; if_c.ID_branch_taken = 1'b0; if_c.ID_jump = 1'b0;
    endtask

    initial begin
        idle_all();

        // Reset held for two cycles: outputs forced to the bubble pattern.
        for (int i = 0; i < 2; i++) begin
            sample();
            check("rst_pc_write",   if_a.PC_write,     1'b0);
            check("rst_ifid_write", if_a.IFID_write,   1'b0);
            check("rst_ifid_flush", if_a.IFID_flush,   1'b1);
            check("rst_idex_flush", if_a.IDEX_flush,   1'b1);
            check("rst_stall_act",  if_a.stall_active, 1'b1);
            next_cycle();
        end
        rst = 1'b0;
        sample();
        check("post_rst_state_a", if_a.hz_state,   2'b00);
        check("post_rst_state_b", if_b.hz_state,   2'b00);
        check("post_rst_state_c", if_c.hz_state,   2'b00);
        check("post_rst_pc",      if_a.PC_write,   1'b1);
        check("post_rst_ifid_fl", if_a.IFID_flush, 1'b0);
        check("post_rst_idex_fl", if_a.IDEX_flush, 1'b0);

        // Single-cycle load-use on rs (LOAD_STALL_CYCLES=1).
        next_cycle();
        if_a.EX_MemRead = 1'b1; if_a.EX_rd = 5'd8; if_a.ID_rs = 5'd8;
        sample();
        check("lu1_pc",        if_a.PC_write,     1'b0);
        check("lu1_ifid_wr",   if_a.IFID_write,   1'b0);
        check("lu1_idex_fl",   if_a.IDEX_flush,   1'b1);
        check("lu1_ifid_fl",   if_a.IFID_flush,   1'b0);
        check("lu1_stall_act", if_a.stall_active, 1'b1);
        next_cycle();
        idle_all();
        sample();
        check("lu1_after_pc",    if_a.PC_write,   1'b1);
        check("lu1_after_idex",  if_a.IDEX_flush, 1'b0);
        check("lu1_after_state", if_a.hz_state,   2'b00);

        // Register 0 and an unused rt must not stall.
        next_cycle();
        if_a.EX_MemRead = 1'b1; if_a.EX_rd = 5'd0; if_a.ID_rs = 5'd0;
        sample();
        check("r0_no_stall", if_a.PC_write, 1'b1);
        next_cycle();
        if_a.EX_rd = 5'd5; if_a.ID_rs = 5'd3; if_a.ID_rt = 5'd5; if_a.ID_uses_rt = 1'b0;
        sample();
        check("rt_unused_no_stall", if_a.PC_write, 1'b1);
        next_cycle();
        if_a.ID_uses_rt = 1'b1;
        sample();
        check("rt_used_stall", if_a.PC_write, 1'b0);
        next_cycle();
        idle_all();

        // Three-cycle load-use on rt, pulse dropped after one cycle.
        next_cycle();
        if_b.EX_MemRead = 1'b1; if_b.EX_rd = 5'd9; if_b.ID_rt = 5'd9; if_b.ID_uses_rt = 1'b1;
        sample();
        check("lu3_c0_state", if_b.hz_state, 2'b00);
        check("lu3_c0_pc",    if_b.PC_write, 1'b0);
        next_cycle();
        idle_all();
        sample();
        check("lu3_c1_state", if_b.hz_state,   2'b01);
        check("lu3_c1_pc",    if_b.PC_write,   1'b0);
        check("lu3_c1_idex",  if_b.IDEX_flush, 1'b1);
        check("lu3_c1_ifidw", if_b.IFID_write, 1'b0);
        next_cycle();
        sample();
        check("lu3_c2_state", if_b.hz_state, 2'b01);
        check("lu3_c2_pc",    if_b.PC_write, 1'b0);
        next_cycle();
        sample();
        check("lu3_c3_state", if_b.hz_state,   2'b00);
        check("lu3_c3_pc",    if_b.PC_write,   1'b1);
        check("lu3_c3_idex",  if_b.IDEX_flush, 1'b0);

        // Two-cycle jump flush; a load-use during REDIR is ignored.
        next_cycle();
        if_b.ID_jump = 1'b1;
        sample();
        check("jmp_c0_state", if_b.hz_state,   2'b00);
        check("jmp_c0_flush", if_b.IFID_flush, 1'b1);
        check("jmp_c0_pc",    if_b.PC_write,   1'b1);
        next_cycle();
        idle_all();
        if_b.EX_MemRead = 1'b1; if_b.EX_rd = 5'd7; if_b.ID_rs = 5'd7;
        sample();
        check("jmp_c1_state", if_b.hz_state,   2'b10);
        check("jmp_c1_flush", if_b.IFID_flush, 1'b1);
        check("jmp_c1_pc",    if_b.PC_write,   1'b1);
        check("jmp_c1_idex",  if_b.IDEX_flush, 1'b0);
        next_cycle();
        idle_all();
        sample();
        check("jmp_c2_state", if_b.hz_state,   2'b00);
        check("jmp_c2_flush", if_b.IFID_flush, 1'b0);

        // Load-use and taken branch together: stall wins, branch re-resolves afterwards.
        next_cycle();
        if_b.EX_MemRead = 1'b1; if_b.EX_rd = 5'd4; if_b.ID_rs = 5'd4; if_b.ID_branch_taken = 1'b1;
        sample();
        check("lub_c0_pc",    if_b.PC_write,   1'b0);
        check("lub_c0_flush", if_b.IFID_flush, 1'b0);
        check("lub_c0_idex",  if_b.IDEX_flush, 1'b1);
        next_cycle();
        if_b.EX_MemRead = 1'b0;
        sample();
        check("lub_c1_state", if_b.hz_state,   2'b01);
        check("lub_c1_flush", if_b.IFID_flush, 1'b0);
        next_cycle();
        sample();
        check("lub_c2_state", if_b.hz_state, 2'b01);
        next_cycle();
        sample();
        check("lub_c3_state", if_b.hz_state,   2'b00);
        check("lub_c3_flush", if_b.IFID_flush, 1'b1);
        check("lub_c3_pc",    if_b.PC_write,   1'b1);
        next_cycle();
        idle_all();
        sample();
        check("lub_c4_state", if_b.hz_state, 2'b10);
        next_cycle();
        sample();
        check("lub_c5_state", if_b.hz_state, 2'b00);

        // Reset during the second LSTALL cycle of a four-cycle stall.
        next_cycle();
        if_c.EX_MemRead = 1'b1; if_c.EX_rd = 5'd12; if_c.ID_rs = 5'd12;
        sample();
        check("rms_c0_state", if_c.hz_state, 2'b00);
        next_cycle();
        idle_all();
        sample();
        check("rms_c1_state", if_c.hz_state, 2'b01);
        next_cycle();
        rst = 1'b1;
        sample();
        check("rms_c2_state", if_c.hz_state,   2'b01);
        check("rms_c2_pc",    if_c.PC_write,   1'b0);
        check("rms_c2_ifidf", if_c.IFID_flush, 1'b1);
        check("rms_c2_idex",  if_c.IDEX_flush, 1'b1);
`ifdef PIPE_HAZARD_STATS_EN
        check("stats_stall_before_rst", if_c.stall_cnt, 32'd2);
        check("stats_flush_before_rst", if_c.flush_cnt, 32'd0);
`endif
        next_cycle();
        rst = 1'b0;
        sample();
        check("rms_c3_state", if_c.hz_state, 2'b00);
        check("rms_c3_pc",    if_c.PC_write, 1'b1);
`ifdef PIPE_HAZARD_STATS_EN
        check("stats_stall_after_rst", if_c.stall_cnt, 32'd0);
        check("stats_flush_after_rst", if_c.flush_cnt, 32'd0);
        check("stats_b_flush_after_rst", if_b.flush_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
